// File: rtl/opb_register_ppc2simulink_sync.sv
// rtl/opb_register_ppc2simulink_sync.sv - OPB slave control register written by the PPC, read by fabric logic
// Optional OPB_PPC2SL_SHADOW_EN: offset 0 becomes a shadow register committed to the active value by a write to offset 1.
module opb_register_ppc2simulink_sync #(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_5000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_50FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter logic [31:0] C_INIT_VALUE = 32'h0000_0000,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:31]             OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:31]             Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic [31:0]             user_data_out,
    output logic                    user_data_update
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t      state;
    logic [31:0] active_reg;
    logic        hit;
    logic [1:0]  offset;
    logic [31:0] rd_val;

    logic unused_seq;
    localparam bit unused_params = (C_OPB_DWIDTH == 32) && (|C_FAMILY);

    assign unused_seq = OPB_seqAddr;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign user_data_out = active_reg;

    assign hit    = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign offset = OPB_ABus[C_OPB_AWIDTH-4 : C_OPB_AWIDTH-3];

    // BE[i] owns DBus[8i:8i+7], which lands in register bits [31-8i -: 8].
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [0:31] data,
                                                input logic [0:3]  be);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[31-8*i -: 8] = data[8*i +: 8];
        end
        return res;
    endfunction

`ifdef OPB_PPC2SL_SHADOW_EN
    logic [31:0] shadow_reg;

    always_comb begin
        rd_val = 32'h0;
        case (offset)
            2'd0:    rd_val = shadow_reg;
            2'd1:    rd_val = active_reg;
            default: rd_val = 32'h0;
        endcase
    end
`else
    always_comb begin
        rd_val = 32'h0;
        if (offset == 2'd0) rd_val = active_reg;
    end
`endif

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state            <= IDLE;
            active_reg       <= C_INIT_VALUE;
`ifdef OPB_PPC2SL_SHADOW_EN
            shadow_reg       <= C_INIT_VALUE;
`endif
            Sl_xferAck       <= 1'b0;
            Sl_DBus          <= '0;
            user_data_update <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Sl_xferAck       <= 1'b0;
                    Sl_DBus          <= '0;
                    user_data_update <= 1'b0;
                    if (hit) begin
                        state      <= ACK;
                        Sl_xferAck <= 1'b1;
                        if (OPB_RNW) begin
                            // Bus numbering is MSB-first, so this is the mirror of the write mapping.
                            Sl_DBus <= rd_val;
                        end else begin
`ifdef OPB_PPC2SL_SHADOW_EN
                            if (offset == 2'd0) begin
                                shadow_reg <= merge_bytes(shadow_reg, OPB_DBus, OPB_BE);
                            end else if (offset == 2'd1) begin
                                active_reg       <= shadow_reg;
                                user_data_update <= 1'b1;
                            end
`else
                            if (offset == 2'd0) begin
                                active_reg       <= merge_bytes(active_reg, OPB_DBus, OPB_BE);
                                user_data_update <= 1'b1;
                            end
`endif
                        end
                    end
                end
                ACK: begin
                    // A select still asserted here is ignored; it is re-decoded next cycle as a new transfer.
                    state            <= IDLE;
                    Sl_xferAck       <= 1'b0;
                    Sl_DBus          <= '0;
                    user_data_update <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_opb_register_ppc2simulink_sync.sv
// tb/tb_opb_register_ppc2simulink_sync.sv - scoreboard bench for the PPC-to-fabric OPB control register
module tb_opb_register_ppc2simulink_sync;

    localparam logic [31:0] BASE = 32'h0100_5000;
    localparam logic [31:0] HIGH = 32'h0100_50FF;
    localparam logic [31:0] INIT = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw;
    logic        sel;
    logic        seq_addr;
    logic [0:31] sl_dbus;
    logic        sl_xfer_ack;
    logic        sl_err_ack;
    logic        sl_retry;
    logic        sl_tout_sup;
    logic [31:0] udo;
    logic        upd;

    typedef struct {
        logic [31:0] dbus;
        logic [31:0] udo;
        logic        upd;
        logic        chk_upd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    opb_register_ppc2simulink_sync #(
        .C_BASEADDR  (BASE),
        .C_HIGHADDR  (HIGH),
        .C_INIT_VALUE(INIT)
    ) dut (
        .OPB_Clk         (clk),
        .OPB_Rst_n       (rst_n),
        .OPB_ABus        (abus),
        .OPB_BE          (be),
        .OPB_DBus        (dbus),
        .OPB_RNW         (rnw),
        .OPB_select      (sel),
        .OPB_seqAddr     (seq_addr),
        .Sl_DBus         (sl_dbus),
        .Sl_xferAck      (sl_xfer_ack),
        .Sl_errAck       (sl_err_ack),
        .Sl_retry        (sl_retry),
        .Sl_toutSup      (sl_tout_sup),
        .user_data_out   (udo),
        .user_data_update(upd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack pops one expectation; outside ack the OR-bus and strobe must be quiet.
    always @(negedge clk) begin
        if (sl_xfer_ack === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_dbus", sl_dbus, e.dbus);
                chk("ack_user_data", udo, e.udo);
                if (e.chk_upd) chk("ack_update", {31'd0, upd}, {31'd0, e.upd});
            end
        end else begin
            chk("idle_dbus_zero", sl_dbus, 32'h0);
            chk("idle_update_zero", {31'd0, upd}, 32'h0);
        end
    end

    task automatic xfer(input logic r, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] b, input logic s, input logic exp_ack,
                        input logic [31:0] exp_dbus, input logic [31:0] exp_udo,
                        input logic exp_upd, input logic chk_upd);
        exp_t e;
        if (exp_ack) begin
            e.dbus = exp_dbus; e.udo = exp_udo; e.upd = exp_upd; e.chk_upd = chk_upd;
            sb.push_back(e);
        end
        rnw = r; abus = addr; dbus = data; be = b; sel = s;
        @(posedge clk); #1;
        chk("ack_latency", {31'd0, sl_xfer_ack}, {31'd0, exp_ack});
        sel = 1'b0; abus = '0; dbus = '0; be = '0;
        @(posedge clk); #1;
        chk("ack_one_cycle", {31'd0, sl_xfer_ack}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0; seq_addr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_udo", udo, INIT);
        chk("rst_ack", {31'd0, sl_xfer_ack}, 32'h0);
        chk("rst_dbus", sl_dbus, 32'h0);
        chk("rst_update", {31'd0, upd}, 32'h0);
        chk("tied_outputs", {29'd0, sl_err_ack, sl_retry, sl_tout_sup}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("hold_udo", udo, INIT);

        // rnw addr data be sel exp_ack exp_dbus exp_udo exp_upd chk_upd
        xfer(0, BASE,        32'hDEAD_BEEF, 4'b1111, 1, 1, 32'h0,          32'hDEAD_BEEF, 1, 1);
        xfer(0, BASE,        32'h1122_3344, 4'b0100, 1, 1, 32'h0,          32'hDE22_BEEF, 1, 1);
        xfer(1, BASE,        32'h0,         4'b1111, 1, 1, 32'hDE22_BEEF,  32'hDE22_BEEF, 0, 1);
        xfer(0, BASE + 8,    32'hFFFF_FFFF, 4'b1111, 1, 1, 32'h0,          32'hDE22_BEEF, 0, 1);
        xfer(1, BASE + 8,    32'h0,         4'b1111, 1, 1, 32'h0,          32'hDE22_BEEF, 0, 1);
        xfer(0, BASE,        32'h0,         4'b0000, 1, 1, 32'h0,          32'hDE22_BEEF, 0, 0);
        xfer(0, BASE,        32'hA5A5_A5A5, 4'b1001, 1, 1, 32'h0,          32'hA522_BEA5, 1, 1);
        xfer(1, HIGH - 3,    32'h0,         4'b1111, 1, 1, 32'h0,          32'hA522_BEA5, 0, 1);
        xfer(0, HIGH + 1,    32'h0,         4'b1111, 1, 0, 32'h0,          32'h0,         0, 0);
        xfer(0, BASE - 4,    32'h0,         4'b1111, 1, 0, 32'h0,          32'h0,         0, 0);
        xfer(0, BASE,        32'h0,         4'b1111, 0, 0, 32'h0,          32'h0,         0, 0);
        chk("no_ack_no_write", udo, 32'hA522_BEA5);
`ifdef OPB_PPC2SL_SHADOW_EN
        xfer(0, BASE,        32'hCAFE_F00D, 4'b1111, 1, 1, 32'h0,          32'hA522_BEA5, 0, 1);
        xfer(1, BASE,        32'h0,         4'b1111, 1, 1, 32'hCAFE_F00D,  32'hA522_BEA5, 0, 1);
        xfer(0, BASE + 4,    32'h0,         4'b0000, 1, 1, 32'h0,          32'hCAFE_F00D, 1, 1);
        xfer(1, BASE + 4,    32'h0,         4'b1111, 1, 1, 32'hCAFE_F00D,  32'hCAFE_F00D, 0, 1);
`else
        xfer(0, BASE + 4,    32'hCAFE_F00D, 4'b1111, 1, 1, 32'h0,          32'hA522_BEA5, 0, 1);
        xfer(1, BASE + 4,    32'h0,         4'b1111, 1, 1, 32'h0,          32'hA522_BEA5, 0, 1);
        xfer(0, BASE,        32'hCAFE_F00D, 4'b1111, 1, 1, 32'h0,          32'hCAFE_F00D, 1, 1);
`endif

        // Select held high across the ACK cycle: two separate transfers, one cycle apart.
        begin
            exp_t e;
            e.dbus = 32'hCAFE_F00D; e.udo = 32'hCAFE_F00D; e.upd = 1'b0; e.chk_upd = 1'b1;
            sb.push_back(e);
            sb.push_back(e);
            rnw = 1'b1; abus = BASE; be = 4'b1111; sel = 1'b1;
            @(posedge clk); #1;
            chk("b2b_first_ack", {31'd0, sl_xfer_ack}, 32'd1);
            @(posedge clk); #1;
            chk("b2b_gap", {31'd0, sl_xfer_ack}, 32'd0);
            @(posedge clk); #1;
            chk("b2b_second_ack", {31'd0, sl_xfer_ack}, 32'd1);
            sel = 1'b0;
            @(posedge clk); #1;
        end

        // Reset landing in the ACK cycle must kill the ack immediately.
        rnw = 1'b0; abus = BASE; dbus = 32'h0BAD_0BAD; be = 4'b1111; sel = 1'b1;
        @(posedge clk); #1;
        chk("pre_reset_ack", {31'd0, sl_xfer_ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_ack_drop", {31'd0, sl_xfer_ack}, 32'd0);
        chk("async_reset_udo", udo, INIT);
        sel = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, BASE,        32'h0,         4'b1111, 1, 1, INIT,           INIT,          0, 1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
